// File: rtl/reg_file.sv
// Parameterised register file: asynchronous combinational read, single write port,
// per-word reset image loaded asynchronously while reset is high.
module reg_file #(
  parameter int unsigned                     WORD_W      = 32,
  parameter int unsigned                     NUM_WORDS   = 32,
  parameter int unsigned                     SEL_W       = 5,
  parameter logic [NUM_WORDS*WORD_W-1:0]     RESET_WORDS = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wen,
  input  logic [SEL_W-1:0]  wsel,
  input  logic [WORD_W-1:0] wdata,
  input  logic [SEL_W-1:0]  rsel,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [NUM_WORDS];
  logic              wsel_ok;
  logic              rsel_ok;

  // Range checks only exist when the select space exceeds the word count.
  generate
    if (NUM_WORDS < (64'd1 << SEL_W)) begin : g_range_chk
      assign wsel_ok = (wsel < SEL_W'(NUM_WORDS));
      assign rsel_ok = (rsel < SEL_W'(NUM_WORDS));
    end else begin : g_full_range
      assign wsel_ok = 1'b1;
      assign rsel_ok = 1'b1;
    end
  endgenerate

  // Word 0 sits in the most-significant slice of the reset image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        mem[i] <= RESET_WORDS[(int'(NUM_WORDS) - 1 - i)*int'(WORD_W) +: WORD_W];
      end
    end else if (wen && wsel_ok) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        if (wsel == SEL_W'(i)) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rsel_ok) begin
      rdata = mem[rsel];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a full-range 4-word instance and a 3-word
// instance exercising out-of-range select handling.
module tb_reg_file;

  localparam int unsigned WORD_W = 32;
  localparam logic [4*WORD_W-1:0] IMG_A =
    {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  localparam logic [3*WORD_W-1:0] IMG_B =
    {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};

  logic              clk = 1'b0;
  logic              reset;
  logic              wen_a, wen_b;
  logic [1:0]        wsel_a, wsel_b, rsel_a, rsel_b;
  logic [WORD_W-1:0] wdata_a, wdata_b, rdata_a, rdata_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_file #(.WORD_W(WORD_W), .NUM_WORDS(4), .SEL_W(2), .RESET_WORDS(IMG_A)) u_dut_a (
    .clk(clk), .reset(reset), .wen(wen_a), .wsel(wsel_a), .wdata(wdata_a),
    .rsel(rsel_a), .rdata(rdata_a)
  );

  reg_file #(.WORD_W(WORD_W), .NUM_WORDS(3), .SEL_W(2), .RESET_WORDS(IMG_B)) u_dut_b (
    .clk(clk), .reset(reset), .wen(wen_b), .wsel(wsel_b), .wdata(wdata_b),
    .rsel(rsel_b), .rdata(rdata_b)
  );

  task automatic check(input string tag, input logic [WORD_W-1:0] got,
                       input logic [WORD_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_a(input string tag, input logic [1:0] sel,
                        input logic [WORD_W-1:0] exp);
    rsel_a = sel;
    #1;
    check(tag, rdata_a, exp);
  endtask

  task automatic read_b(input string tag, input logic [1:0] sel,
                        input logic [WORD_W-1:0] exp);
    rsel_b = sel;
    #1;
    check(tag, rdata_b, exp);
  endtask

  initial begin
    reset   = 1'b0;
    wen_a   = 1'b0; wsel_a = '0; wdata_a = '0; rsel_a = '0;
    wen_b   = 1'b0; wsel_b = '0; wdata_b = '0; rsel_b = '0;

    // Reset asserted before any clock edge: image must appear asynchronously.
    #1 reset = 1'b1;
    read_a("rst_a_w0", 2'd0, 32'h11111111);
    read_a("rst_a_w1", 2'd1, 32'h22222222);
    read_a("rst_a_w2", 2'd2, 32'h33333333);
    read_a("rst_a_w3", 2'd3, 32'h44444444);
    read_b("rst_b_w0", 2'd0, 32'hA0A0A0A0);
    read_b("rst_b_w1", 2'd1, 32'hB1B1B1B1);
    read_b("rst_b_w2", 2'd2, 32'hC2C2C2C2);
    read_b("rst_b_oor", 2'd3, 32'h00000000);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Write and read back.
    wen_a = 1'b1; wsel_a = 2'd2; wdata_a = 32'hDEADBEEF;
    @(posedge clk); #1;
    wen_a = 1'b0;
    read_a("wr_w2", 2'd2, 32'hDEADBEEF);
    read_a("wr_w1_keep", 2'd1, 32'h22222222);

    // No bypass: old value before the edge, new value after.
    @(negedge clk);
    wen_a = 1'b1; wsel_a = 2'd3; wdata_a = 32'hCAFEF00D;
    read_a("nobyp_pre", 2'd3, 32'h44444444);
    @(posedge clk); #1;
    wen_a = 1'b0;
    check("nobyp_post", rdata_a, 32'hCAFEF00D);

    // Write disabled over several edges.
    @(negedge clk);
    wen_a = 1'b0; wsel_a = 2'd0; wdata_a = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    read_a("wdis_w0", 2'd0, 32'h11111111);
    read_a("wdis_w2", 2'd2, 32'hDEADBEEF);

    // Async reset between edges discards prior writes at once.
    @(negedge clk);
    #2 reset = 1'b1;
    read_a("mid_rst_w2", 2'd2, 32'h33333333);
    read_a("mid_rst_w3", 2'd3, 32'h44444444);

    // Writes blocked while reset is held across an edge.
    wen_a = 1'b1; wsel_a = 2'd0; wdata_a = 32'h12345678;
    @(posedge clk); #1;
    read_a("rst_blk_w0", 2'd0, 32'h11111111);

    // First write after release lands on the next edge.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    wen_a = 1'b0;
    read_a("post_rst_w0", 2'd0, 32'h12345678);
    read_a("post_rst_w1", 2'd1, 32'h22222222);

    // Out-of-range write on the 3-word instance changes nothing.
    @(negedge clk);
    wen_b = 1'b1; wsel_b = 2'd3; wdata_b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    wen_b = 1'b0;
    read_b("oor_wr_w0", 2'd0, 32'hA0A0A0A0);
    read_b("oor_wr_w1", 2'd1, 32'hB1B1B1B1);
    read_b("oor_wr_w2", 2'd2, 32'hC2C2C2C2);
    read_b("oor_rd", 2'd3, 32'h00000000);

    // In-range write on the 3-word instance still works.
    @(negedge clk);
    wen_b = 1'b1; wsel_b = 2'd2; wdata_b = 32'h5A5A0F0F;
    @(posedge clk); #1;
    wen_b = 1'b0;
    read_b("b_wr_w2", 2'd2, 32'h5A5A0F0F);
    read_b("b_wr_w0", 2'd0, 32'hA0A0A0A0);
    read_b("b_oor_after", 2'd3, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
